debounce_pulso_acao: RTL

DEBOUNCE_PULSO_ACAO -- requirements
Module: debounce_pulso_acao

---
 rtl/debounce_pulso_acao.sv | 136 +++++++++++++
 1 files changed

// File: rtl/debounce_pulso_acao.sv
// -----------------------------------------------------------------------------
// debounce_pulso_acao
//
// Debounces a raw, bouncing, active-low push-button and turns each accepted
// press into a single one-clock action pulse for the sequencer. A level change
// is accepted only after the synchronized input has held the new level for
// DEBOUNCE_CICLOS consecutive cycles in the matching wait state; any bounce
// back to the old level clears the counter and returns to the stable state.
//
// Parameters
//   DEBOUNCE_CICLOS  stable cycles required to accept a change (2..2^24)
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   reset          synchronous, active-high reset
//   botao_n        raw push-button, active low, asynchronous to clk
//   action_pulso   registered one-cycle pulse per accepted press
//   botao_estavel  registered debounced level, 1 = pressed
//   estado_dbg     current FSM state encoding, for debug LEDs
// -----------------------------------------------------------------------------
module debounce_pulso_acao #(
  parameter int unsigned DEBOUNCE_CICLOS = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       botao_n,
  output logic       action_pulso,
  output logic       botao_estavel,
  output logic [1:0] estado_dbg
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    SOLTO        = 2'b00,
    ESPERA_PRESS = 2'b01,
    PRESSIONADO  = 2'b10,
    ESPERA_SOLTA = 2'b11
  } estado_t;

  // Synchronizer: the inverted button is sampled twice; only sync2_q is used.
  logic          sync1_q, sync2_q;
  estado_t       state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          pulso_q, pulso_d;
  logic          estavel_q, estavel_d;

  logic s;
  assign s = sync2_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulso_d = 1'b0;

    unique case (state_q)
      SOLTO: begin
        if (s) begin
          state_d = ESPERA_PRESS;
          cnt_d   = '0;
        end
      end

      ESPERA_PRESS: begin
        if (!s) begin
          // Bounce back to released: qualification restarts from scratch.
          state_d = SOLTO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          // The only transition that produces an action pulse.
          state_d = PRESSIONADO;
          cnt_d   = '0;
          pulso_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      PRESSIONADO: begin
        if (!s) begin
          state_d = ESPERA_SOLTA;
          cnt_d   = '0;
        end
      end

      ESPERA_SOLTA: begin
        if (s) begin
          // Release bounce: back to pressed without a new pulse.
          state_d = PRESSIONADO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = SOLTO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = SOLTO;
        cnt_d   = '0;
      end
    endcase

    // Debounced level follows the next state so it is registered with it.
    estavel_d = (state_d == PRESSIONADO) || (state_d == ESPERA_SOLTA);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, which keeps the two synchronizer stages distinct.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= SOLTO;
      cnt_q     <= '0;
      pulso_q   <= 1'b0;
      estavel_q <= 1'b0;
    end else begin
      sync1_q   <= ~botao_n;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulso_q   <= pulso_d;
      estavel_q <= estavel_d;
    end
  end

  assign action_pulso  = pulso_q;
  assign botao_estavel = estavel_q;
  assign estado_dbg    = state_q;

endmodule
